// File: rtl/fx_bus_mux.sv
// CPU-side bus multiplexer: latches a slave select, waits for its ready, returns lane-sized read data.
// Optional wait timeout is built only when FX_BUS_TIMEOUT_EN is defined.
module fx_bus_mux #(
  parameter int NSLV   = 5,
  parameter int DW     = 32,
  parameter int TO_CYC = 1023
) (
  input  logic                 CLK,
  input  logic                 RES,
  input  logic                 CE,
  input  logic                 BCYSTn,
  input  logic                 RW,
  input  logic [NSLV-1:0]      SEL,
  input  logic [2*NSLV-1:0]    SLV_W,
  input  logic [NSLV*DW-1:0]   SLV_DO,
  input  logic [NSLV-1:0]      SLV_READYn,
  output logic [DW-1:0]        D_I,
  output logic                 READYn,
  output logic                 BUS_ERR,
  output logic [1:0]           ERR_CODE
);

  localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;

  if (NSLV < 1 || NSLV > 8) begin : g_bad_nslv
    $error("fx_bus_mux: NSLV must be 1..8");
  end
  if (DW != 16 && DW != 32) begin : g_bad_dw
    $error("fx_bus_mux: DW must be 16 or 32");
  end
  if (TO_CYC < 1 || TO_CYC > 65535) begin : g_bad_to
    $error("fx_bus_mux: TO_CYC must be 1..65535");
  end

  typedef enum logic [1:0] {IDLE, WAIT, DONE, ERR} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d, win_idx;
  logic [1:0]      lane_q, lane_d, win_lane;
  logic            rw_q, rw_d;
  logic [DW-1:0]   d_i_q, d_i_d;
  logic            readyn_q, readyn_d;
  logic            bus_err_q, bus_err_d;
  logic [1:0]      err_code_q, err_code_d;
  logic [DW-1:0]   slv_word, lane_data;
  logic            multi_sel, slv_ready;

`ifdef FX_BUS_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYC + 1);
  logic [CW-1:0]   cnt_q, cnt_d;
`endif

  // Lowest set select bit wins; its lane width is captured alongside the index.
  always_comb begin
    win_idx  = '0;
    win_lane = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (SEL[i]) begin
        win_idx  = IW'(i);
        win_lane = SLV_W[2*i +: 2];
      end
    end
  end

  assign multi_sel = |(SEL & (SEL - NSLV'(1)));
  assign slv_word  = SLV_DO[int'(idx_q)*DW +: DW];
  assign slv_ready = ~SLV_READYn[idx_q];

  always_comb begin
    lane_data = '0;
    case (lane_q)
      2'b00:   lane_data[7:0]  = slv_word[7:0];
      2'b01:   lane_data[15:0] = slv_word[15:0];
      default: lane_data       = slv_word;
    endcase
  end

  // READYn and BUS_ERR are produced while in DONE/ERR, so they appear one CE edge after the state is entered.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    lane_d     = lane_q;
    rw_d       = rw_q;
    d_i_d      = d_i_q;
    readyn_d   = readyn_q;
    bus_err_d  = bus_err_q;
    err_code_d = err_code_q;
`ifdef FX_BUS_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    if (CE) begin
      readyn_d  = 1'b1;
      bus_err_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (!BCYSTn) begin
            idx_d  = win_idx;
            lane_d = win_lane;
            rw_d   = RW;
            if (SEL == '0) begin
              state_d    = ERR;
              err_code_d = 2'b01;
            end else begin
              state_d    = WAIT;
              err_code_d = multi_sel ? 2'b11 : 2'b00;
`ifdef FX_BUS_TIMEOUT_EN
              cnt_d      = '0;
`endif
            end
          end
        end
        WAIT: begin
          if (slv_ready) begin
            state_d = DONE;
            if (rw_q) d_i_d = lane_data;
          end
`ifdef FX_BUS_TIMEOUT_EN
          else if (cnt_q == CW'(TO_CYC)) begin
            state_d    = ERR;
            err_code_d = 2'b10;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
`endif
        end
        DONE: begin
          readyn_d  = 1'b0;
          bus_err_d = (err_code_q == 2'b11);
          state_d   = IDLE;
        end
        ERR: begin
          readyn_d  = 1'b0;
          bus_err_d = 1'b1;
          if (rw_q) d_i_d = '0;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      lane_q     <= '0;
      rw_q       <= 1'b0;
      d_i_q      <= '0;
      readyn_q   <= 1'b1;
      bus_err_q  <= 1'b0;
      err_code_q <= 2'b00;
`ifdef FX_BUS_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      lane_q     <= lane_d;
      rw_q       <= rw_d;
      d_i_q      <= d_i_d;
      readyn_q   <= readyn_d;
      bus_err_q  <= bus_err_d;
      err_code_q <= err_code_d;
`ifdef FX_BUS_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign D_I      = d_i_q;
  assign READYn   = readyn_q;
  assign BUS_ERR  = bus_err_q;
  assign ERR_CODE = err_code_q;

endmodule

// File: tb/tb_fx_bus_mux.sv
// Self-checking bench for fx_bus_mux: directed vector table, reset/CE sequences, randomized cycles vs a model.
module tb_fx_bus_mux;

  localparam int NSLV = 5;
  localparam int DW   = 32;
  localparam int TO   = 4;
`ifdef FX_BUS_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic                CLK = 1'b0;
  logic                RES, CE, BCYSTn, RW;
  logic [NSLV-1:0]     SEL;
  logic [2*NSLV-1:0]   SLV_W;
  logic [NSLV*DW-1:0]  SLV_DO;
  logic [NSLV-1:0]     SLV_READYn;
  logic [DW-1:0]       D_I;
  logic                READYn, BUS_ERR;
  logic [1:0]          ERR_CODE;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_di;

  fx_bus_mux #(.NSLV(NSLV), .DW(DW), .TO_CYC(TO)) dut (
    .CLK(CLK), .RES(RES), .CE(CE), .BCYSTn(BCYSTn), .RW(RW), .SEL(SEL),
    .SLV_W(SLV_W), .SLV_DO(SLV_DO), .SLV_READYn(SLV_READYn),
    .D_I(D_I), .READYn(READYn), .BUS_ERR(BUS_ERR), .ERR_CODE(ERR_CODE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]   sel;
    logic [9:0]   w;
    logic         rw;
    logic [159:0] data;
    int           delay;
    logic [31:0]  exp_di;
    logic [1:0]   exp_code;
    logic         exp_berr;
    int           exp_lat;
  } vec_t;

  vec_t tbl[8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Expected result of one bus cycle, from the rules: lowest select wins, lane masks by width, errors zero read data.
  task automatic modelTxn(input logic [4:0] s, input logic [9:0] w, input logic rw_i,
                          input logic [159:0] data, input int delay,
                          output logic [31:0] e_di, output logic [1:0] e_code,
                          output logic e_berr, output int e_lat);
    int win = -1;
    logic [1:0] lw;
    longint word, modulus;
    for (int i = 0; i < NSLV; i++) if (s[i] && win < 0) win = i;
    e_di = model_di;
    if (win < 0) begin
      e_code = 2'b01; e_berr = 1'b1; e_lat = 1;
      if (rw_i) e_di = 32'h0;
    end else if (TIMEOUT_ON && delay > TO) begin
      e_code = 2'b10; e_berr = 1'b1; e_lat = TO + 2;
      if (rw_i) e_di = 32'h0;
    end else begin
      lw      = w[2*win +: 2];
      word    = longint'(data[32*win +: 32]);
      modulus = (lw == 2'b00) ? 256 : (lw == 2'b01) ? 65536 : 64'h1_0000_0000;
      e_code  = ($countones(s) > 1) ? 2'b11 : 2'b00;
      e_berr  = ($countones(s) > 1);
      e_lat   = delay + 2;
      if (rw_i) e_di = 32'(word % modulus);
    end
  endtask

  // Runs one bus cycle; the selected slave goes ready 'delay' WAIT edges after the latch, noise elsewhere.
  task automatic applyStimulus(input logic [4:0] s, input logic [9:0] w, input logic rw_i,
                               input logic [159:0] data, input int delay,
                               input logic [31:0] e_di, input logic [1:0] e_code,
                               input logic e_berr, input int e_lat);
    int win = -1;
    int k = 0;
    bit got = 0;
    for (int i = 0; i < NSLV; i++) if (s[i] && win < 0) win = i;
    @(negedge CLK);
    BCYSTn = 1'b0; SEL = s; SLV_W = w; RW = rw_i; SLV_DO = data; SLV_READYn = '1;
    @(posedge CLK);
    while (!got && k < 40) begin
      @(negedge CLK);
      if (READYn === 1'b0) got = 1;
      else begin
        BCYSTn     = 1'($urandom_range(0, 1));
        SEL        = 5'($urandom);
        RW         = 1'($urandom_range(0, 1));
        SLV_READYn = 5'($urandom);
        if (win >= 0) SLV_READYn[win] = (k != delay);
        k++;
      end
    end
    BCYSTn = 1'b1; SLV_READYn = '1;
    checkOutput("latency", k, e_lat);
    checkOutput("d_i", D_I, e_di);
    checkOutput("err_code", {30'h0, ERR_CODE}, {30'h0, e_code});
    checkOutput("bus_err", {31'h0, BUS_ERR}, {31'h0, e_berr});
    @(negedge CLK);
    checkOutput("readyn_release", {31'h0, READYn}, 32'h1);
    checkOutput("bus_err_release", {31'h0, BUS_ERR}, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] e_di;
    logic [1:0]  e_code;
    logic        e_berr;
    int          e_lat, bad;
    logic [4:0]  s;
    logic [9:0]  w;
    logic        rw_r;
    logic [159:0] data;
    int          delay;

    tbl[0] = '{5'b00100, 10'h010, 1'b1, {32'h11111111, 32'h22222222, 32'hDEADBEEF, 32'h44444444, 32'h55555555},
               3, 32'h0000BEEF, 2'b00, 1'b0, 5};
    tbl[1] = '{5'b00001, 10'h000, 1'b0, {32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF},
               0, 32'h0000BEEF, 2'b00, 1'b0, 2};
    tbl[2] = '{5'b00000, 10'h3FF, 1'b1, {5{32'hA5A5A5A5}}, 0, 32'h00000000, 2'b01, 1'b1, 1};
    tbl[3] = '{5'b00110, 10'h000, 1'b1, {32'h0, 32'h0, 32'h99999999, 32'h0, 32'h12345678} << 32,
               1, 32'h00000078, 2'b11, 1'b1, 3};
    tbl[4] = '{5'b00000, 10'h000, 1'b0, {5{32'h0}}, 0, 32'h00000078, 2'b01, 1'b1, 1};
    tbl[5] = '{5'b10000, 10'h200, 1'b1, {32'hCAFEF00D, 32'h0, 32'h0, 32'h0, 32'h0},
               2, 32'hCAFEF00D, 2'b00, 1'b0, 4};
    tbl[6] = '{5'b01000, 10'h040, 1'b1, {32'h0, 32'hA5A51234, 32'h0, 32'h0, 32'h0},
               0, 32'h00001234, 2'b00, 1'b0, 2};
    tbl[7] = '{5'b11111, 10'h003, 1'b1, {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h89ABCDEF},
               1, 32'h89ABCDEF, 2'b11, 1'b1, 3};

    RES = 1'b1; CE = 1'b1; BCYSTn = 1'b1; RW = 1'b0; SEL = '0; SLV_W = '0; SLV_DO = '0; SLV_READYn = '1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checkOutput("reset_readyn", {31'h0, READYn}, 32'h1);
    checkOutput("reset_bus_err", {31'h0, BUS_ERR}, 32'h0);
    checkOutput("reset_err_code", {30'h0, ERR_CODE}, 32'h0);
    checkOutput("reset_d_i", D_I, 32'h0);
    RES = 1'b0;
    model_di = 32'h0;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i].sel, tbl[i].w, tbl[i].rw, tbl[i].data, tbl[i].delay,
                    tbl[i].exp_di, tbl[i].exp_code, tbl[i].exp_berr, tbl[i].exp_lat);
      model_di = tbl[i].exp_di;
    end

    // Reset must take effect even with CE low.
    @(negedge CLK); CE = 1'b0; RES = 1'b1;
    @(posedge CLK);
    @(negedge CLK); RES = 1'b0; CE = 1'b1;
    checkOutput("reset_ce0_d_i", D_I, 32'h0);
    checkOutput("reset_ce0_err_code", {30'h0, ERR_CODE}, 32'h0);
    model_di = 32'h0;

    // Reset in WAIT aborts the cycle: the late ready must not produce a READYn pulse.
    @(negedge CLK);
    BCYSTn = 1'b0; SEL = 5'b00100; RW = 1'b1; SLV_W = '1; SLV_DO = {5{32'h5A5AC3C3}}; SLV_READYn = '1;
    @(posedge CLK);
    @(negedge CLK); BCYSTn = 1'b1; RES = 1'b1;
    @(posedge CLK);
    @(negedge CLK); RES = 1'b0; SLV_READYn = '0;
    bad = 0;
    repeat (4) begin
      @(negedge CLK);
      if (READYn !== 1'b1) bad++;
    end
    checkOutput("reset_abort_readyn", bad, 0);
    checkOutput("reset_abort_d_i", D_I, 32'h0);
    SLV_READYn = '1;
    data = {5{32'h0000F00D}};
    modelTxn(5'b00100, 10'h3FF, 1'b1, data, 1, e_di, e_code, e_berr, e_lat);
    applyStimulus(5'b00100, 10'h3FF, 1'b1, data, 1, e_di, e_code, e_berr, e_lat);
    model_di = e_di;

    // CE low freezes WAIT and the READYn pulse.
    @(negedge CLK);
    BCYSTn = 1'b0; SEL = 5'b00001; RW = 1'b1; SLV_W = '0; SLV_DO = {128'h0, 32'h000001AB}; SLV_READYn = '1;
    @(posedge CLK);
    @(negedge CLK); BCYSTn = 1'b1; CE = 1'b0; SLV_READYn = 5'b11110;
    bad = 0;
    repeat (3) begin
      @(negedge CLK);
      if (READYn !== 1'b1 || D_I !== model_di) bad++;
    end
    checkOutput("ce0_wait_hold", bad, 0);
    CE = 1'b1;
    @(negedge CLK); SLV_READYn = '1;
    checkOutput("ce_ready_edge_readyn", {31'h0, READYn}, 32'h1);
    checkOutput("ce_ready_edge_d_i", D_I, 32'h000000AB);
    @(negedge CLK);
    checkOutput("ce_done_readyn", {31'h0, READYn}, 32'h0);
    CE = 1'b0;
    repeat (2) @(negedge CLK);
    checkOutput("ce0_readyn_hold", {31'h0, READYn}, 32'h0);
    CE = 1'b1;
    @(negedge CLK);
    checkOutput("ce_readyn_release", {31'h0, READYn}, 32'h1);
    model_di = 32'h000000AB;

`ifdef FX_BUS_TIMEOUT_EN
    data = {5{32'h77777777}};
    modelTxn(5'b00001, 10'h3FF, 1'b1, data, 100, e_di, e_code, e_berr, e_lat);
    applyStimulus(5'b00001, 10'h3FF, 1'b1, data, 100, e_di, e_code, e_berr, e_lat);
    model_di = e_di;
`endif

    repeat (40) begin
      s = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) s = 5'b0;
      w     = 10'($urandom);
      rw_r  = 1'($urandom_range(0, 1));
      data  = {$urandom, $urandom, $urandom, $urandom, $urandom};
      delay = $urandom_range(0, 6);
      modelTxn(s, w, rw_r, data, delay, e_di, e_code, e_berr, e_lat);
      applyStimulus(s, w, rw_r, data, delay, e_di, e_code, e_berr, e_lat);
      model_di = e_di;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fx_bus_mux.md
FX_BUS_MUX -- requirements
Module: fx_bus_mux

Interface
- Parameters (one per line: name, default, meaning)
REQ-001 NSLV, 5: number of slave ports; legal range 1..8.
REQ-002 DW, 32: CPU data width in bits; legal values 16 or 32.
REQ-003 TO_CYC, 1023: CE-cycle timeout limit while waiting on a slave; legal range 1..65535.
- Ports (one per line: name, direction, width, meaning; clock and reset first)
REQ-004 CLK  in  1  sole clock; all state updates on the rising edge.
REQ-005 RES  in  1  reset; synchronous and active-high.
REQ-006 CE  in  1  CPU clock enable; state advances only on edges where CE=1.
REQ-007 BCYSTn  in  1  CPU bus-cycle start strobe, active-low.
REQ-008 RW  in  1  1=read, 0=write; sampled with BCYSTn.
REQ-009 SEL  in  NSLV  active-high slave selects, decoded from the chip-enables.
REQ-010 SLV_W  in  2*NSLV  per-slave lane width: 00=8-bit, 01=16-bit, 1x=32-bit.
REQ-011 SLV_DO  in  NSLV*DW  slave read data; slave i occupies bits [i*DW +: DW].
REQ-012 SLV_READYn  in  NSLV  per-slave ready, active-low.
REQ-013 D_I  out  DW  registered read data to the CPU.
REQ-014 READYn  out  1  cycle-complete strobe to the CPU, active-low.
REQ-015 BUS_ERR  out  1  one-CE-cycle error pulse.
REQ-016 ERR_CODE  out  2  error cause: 00=none, 01=unmapped, 10=timeout, 11=multi-select.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, WAIT, DONE and ERR.
REQ-018 In IDLE, on a CE edge with BCYSTn=0, the block SHALL latch SEL, SLV_W and RW.
REQ-019 On that same edge it SHALL go to ERR with ERR_CODE=01 if SEL is all zero; otherwise it SHALL go to WAIT.
REQ-020 If more than one SEL bit is set, the lowest index SHALL win, ERR_CODE SHALL be set to 11, and the cycle SHALL proceed normally with BUS_ERR pulsed on its completion.
REQ-021 In WAIT, on a CE edge where the latched slave's SLV_READYn=0, the block SHALL go to DONE.
REQ-022 On that edge, for reads, D_I SHALL load the slave data zero-extended to lane width: [7:0] for 8-bit, [15:0] for 16-bit, full DW for 32-bit.
REQ-023 Writes SHALL leave D_I unchanged.
REQ-024 DONE and ERR SHALL each last exactly one CE cycle with READYn=0, then return to IDLE.
REQ-025 Latency: if SLV_READYn is sampled low at CE edge n, READYn SHALL be low after edge n+1 and high again after edge n+2.
REQ-026 ERR SHALL drive READYn=0 and BUS_ERR=1, and SHALL load D_I with 0 on reads.
REQ-027 A BCYSTn assertion outside IDLE SHALL be ignored.
REQ-028 A BCYSTn assertion in the DONE or ERR cycle SHALL NOT start a new cycle until IDLE.
REQ-029 SEL changes after the latch edge SHALL be ignored until IDLE.
REQ-030 SLV_READYn of non-latched slaves SHALL be ignored.
REQ-031 With CE=0 all state, counters and outputs SHALL hold.

Reset
REQ-032 On RES=1 at a clock edge, regardless of CE, the block SHALL load: state=IDLE, READYn=1, BUS_ERR=0, ERR_CODE=00, D_I=0, timeout counter=0.
REQ-033 A reset during WAIT, DONE or ERR SHALL abort the cycle with no READYn pulse.

Configuration
REQ-034 The timeout feature SHALL be controlled by the macro FX_BUS_TIMEOUT_EN.
REQ-035 With FX_BUS_TIMEOUT_EN defined, a counter of clog2(TO_CYC+1) bits SHALL clear on entry to WAIT and increment each CE cycle in WAIT.
REQ-036 With FX_BUS_TIMEOUT_EN defined, when the counter equals TO_CYC and ready is still high, the block SHALL go to ERR with ERR_CODE=10.
REQ-037 With FX_BUS_TIMEOUT_EN defined, ready and timeout on the same edge SHALL resolve to DONE, because ready wins.
REQ-038 Without FX_BUS_TIMEOUT_EN, the counter SHALL not be built, WAIT SHALL wait indefinitely, and ERR_CODE=10 SHALL never occur.

Verification
REQ-039 Read with NSLV=5, SEL=00100, SLV_W[5:4]=01, slave 2 data=0xDEADBEEF, ready after 3 CE cycles -> D_I=0x0000BEEF, READYn low for one CE cycle two edges after ready.
REQ-040 Write with SEL=00001, ready immediate -> READYn pulse, D_I unchanged, BUS_ERR=0.
REQ-041 BCYSTn with SEL=0 -> READYn and BUS_ERR low/high one cycle later, ERR_CODE=01, D_I=0.
REQ-042 SEL=00110, 8-bit lane, slave 1 data=0x12345678 -> D_I=0x00000078, BUS_ERR pulse, ERR_CODE=11.
REQ-043 FX_BUS_TIMEOUT_EN, TO_CYC=4, ready never asserted -> ERR after 5 CE cycles in WAIT, ERR_CODE=10.
REQ-044 RES=1 during WAIT, then ready asserted -> no READYn pulse, and the next BCYSTn is accepted normally.
